// File: rtl/tlb_assoc.sv
// tlb_assoc: fully-associative TLB with a one-cycle registered lookup, a fill port
// that picks a slot (matching VPN, then first free entry, then round-robin victim),
// and a flush engine that invalidates one entry per cycle.
// Optional build macro: TLB_PERF_CNT_EN adds saturating user-mode hit/miss counters.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | lookups accepted, fills applied
// FLUSH | clearing entry flush_idx each cycle; lookups stalled, fills dropped

`ifndef EXCEPTION_TYPE_PRIV
`define EXCEPTION_TYPE_PRIV 3'b011
`endif

module tlb_assoc #(
    parameter int N         = 4,
    parameter int VA_WIDTH  = 32,
    parameter int PA_WIDTH  = 32,
    parameter int PAGE_BITS = 12
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_supervisor_mode,
    input  logic                in_req_valid,
    input  logic [VA_WIDTH-1:0] in_virtual_address,
    output logic                out_req_ready,
    output logic                out_resp_valid,
    output logic                out_tlb_hit,
    output logic [PA_WIDTH-1:0] out_physical_address,
    output logic [VA_WIDTH-1:0] out_fault_addr,
    output logic [2:0]          out_exception_vector,
    output logic                out_exception,
    input  logic                in_write_enable,
    input  logic [VA_WIDTH-1:0] in_write_virtual_address,
    input  logic [PA_WIDTH-1:0] in_write_physical_address,
    input  logic                in_flush,
    output logic                out_flush_busy
`ifdef TLB_PERF_CNT_EN
    ,
    output logic [31:0]         out_hit_count,
    output logic [31:0]         out_miss_count
`endif
);

    localparam int VPN_W = VA_WIDTH - PAGE_BITS;
    localparam int PPN_W = PA_WIDTH - PAGE_BITS;
    localparam int PTR_W = $clog2(N);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t             state;
    logic [N-1:0]       valid;
    logic [VPN_W-1:0]   vpn [N];
    logic [PPN_W-1:0]   ppn [N];
    logic [PTR_W-1:0]   repl_ptr;
    logic [PTR_W-1:0]   flush_idx;
    logic               priv_pend;

    logic [VPN_W-1:0]   lk_vpn;
    logic [VPN_W-1:0]   wr_vpn;
    logic [PPN_W-1:0]   wr_ppn;
    logic               accept;
    logic               wr_legal;
    logic               wr_illegal;
    logic               hit_any;
    logic [PPN_W-1:0]   hit_ppn;
    logic               wr_match;
    logic [PTR_W-1:0]   match_idx;
    logic               inv_found;
    logic [PTR_W-1:0]   inv_idx;
    logic [PTR_W-1:0]   fill_idx;
    logic               use_ptr;
    logic [PA_WIDTH-1:0] bypass_pa;
    logic [PA_WIDTH+VA_WIDTH-1:0] bypass_ext;
    logic               unused_bits;

    assign lk_vpn     = in_virtual_address[VA_WIDTH-1:PAGE_BITS];
    assign wr_vpn     = in_write_virtual_address[VA_WIDTH-1:PAGE_BITS];
    assign wr_ppn     = in_write_physical_address[PA_WIDTH-1:PAGE_BITS];
    assign accept     = in_req_valid && out_req_ready;
    // A flush request in IDLE wins over a same-cycle fill; fills during FLUSH vanish.
    assign wr_legal   = in_write_enable && in_supervisor_mode  && (state == IDLE) && !in_flush;
    assign wr_illegal = in_write_enable && !in_supervisor_mode && (state == IDLE) && !in_flush;
    assign bypass_ext = {{PA_WIDTH{1'b0}}, in_virtual_address};
    assign bypass_pa  = bypass_ext[PA_WIDTH-1:0];
    assign unused_bits = ^{in_write_virtual_address[PAGE_BITS-1:0],
                           in_write_physical_address[PAGE_BITS-1:0]};

    // Associative match for the lookup port (fill logic guarantees a unique VPN).
    always_comb begin
        hit_any = 1'b0;
        hit_ppn = '0;
        for (int i = 0; i < N; i++) begin
            if (valid[i] && (vpn[i] == lk_vpn)) begin
                hit_any = 1'b1;
                hit_ppn = ppn[i];
            end
        end
    end

    // Fill slot selection: existing VPN first, then lowest free entry, then victim pointer.
    always_comb begin
        wr_match  = 1'b0;
        match_idx = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!wr_match && valid[i] && (vpn[i] == wr_vpn)) begin
                wr_match  = 1'b1;
                match_idx = PTR_W'(i);
            end
            if (!inv_found && !valid[i]) begin
                inv_found = 1'b1;
                inv_idx   = PTR_W'(i);
            end
        end
        use_ptr  = !wr_match && !inv_found;
        fill_idx = wr_match ? match_idx : (inv_found ? inv_idx : repl_ptr);
    end

    // Control FSM plus the entry table it owns (fills in IDLE, invalidation in FLUSH).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            out_req_ready  <= 1'b0;
            out_flush_busy <= 1'b0;
            flush_idx      <= '0;
            repl_ptr       <= '0;
            valid          <= '0;
            for (int i = 0; i < N; i++) begin
                vpn[i] <= '0;
                ppn[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_flush) begin
                        state          <= FLUSH;
                        out_req_ready  <= 1'b0;
                        out_flush_busy <= 1'b1;
                        flush_idx      <= '0;
                    end else begin
                        out_req_ready  <= 1'b1;
                        out_flush_busy <= 1'b0;
                    end
                    if (wr_legal) begin
                        valid[fill_idx] <= 1'b1;
                        vpn[fill_idx]   <= wr_vpn;
                        ppn[fill_idx]   <= wr_ppn;
                        if (use_ptr) begin
                            repl_ptr <= repl_ptr + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    valid[flush_idx] <= 1'b0;
                    flush_idx        <= flush_idx + 1'b1;
                    if (flush_idx == PTR_W'(N - 1)) begin
                        state          <= IDLE;
                        out_req_ready  <= 1'b1;
                        out_flush_busy <= 1'b0;
                        repl_ptr       <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Registered response; a privilege fault yields to a same-cycle lookup and waits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_resp_valid       <= 1'b0;
            out_tlb_hit          <= 1'b0;
            out_physical_address <= '0;
            out_fault_addr       <= '0;
            out_exception_vector <= 3'b000;
            out_exception        <= 1'b0;
            priv_pend            <= 1'b0;
        end else if (accept) begin
            out_resp_valid       <= 1'b1;
            out_exception_vector <= 3'b000;
            priv_pend            <= priv_pend || wr_illegal;
            if (in_supervisor_mode) begin
                out_tlb_hit          <= 1'b1;
                out_physical_address <= bypass_pa;
                out_fault_addr       <= '0;
                out_exception        <= 1'b0;
            end else if (hit_any) begin
                out_tlb_hit          <= 1'b1;
                out_physical_address <= {hit_ppn, in_virtual_address[PAGE_BITS-1:0]};
                out_fault_addr       <= '0;
                out_exception        <= 1'b0;
            end else begin
                out_tlb_hit          <= 1'b0;
                out_physical_address <= '0;
                out_fault_addr       <= in_virtual_address;
                out_exception        <= 1'b1;
            end
        end else if (wr_illegal || priv_pend) begin
            out_resp_valid       <= 1'b0;
            out_tlb_hit          <= 1'b0;
            out_physical_address <= '0;
            out_fault_addr       <= '0;
            out_exception_vector <= `EXCEPTION_TYPE_PRIV;
            out_exception        <= 1'b1;
            priv_pend            <= 1'b0;
        end else begin
            out_resp_valid       <= 1'b0;
            out_tlb_hit          <= 1'b0;
            out_physical_address <= '0;
            out_fault_addr       <= '0;
            out_exception_vector <= 3'b000;
            out_exception        <= 1'b0;
        end
    end

`ifdef TLB_PERF_CNT_EN
    // Saturating user-mode hit/miss counters; bypass lookups are not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_hit_count  <= '0;
            out_miss_count <= '0;
        end else if (accept && !in_supervisor_mode) begin
            if (hit_any) begin
                if (out_hit_count != 32'hFFFF_FFFF) out_hit_count <= out_hit_count + 1'b1;
            end else begin
                if (out_miss_count != 32'hFFFF_FFFF) out_miss_count <= out_miss_count + 1'b1;
            end
        end
    end
`endif

endmodule
